hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 id_rs, id_rt  input  4 each  source register numbers of the instruction in ID.
REQ-004 id_uses_rs, id_uses_rt  input  1 each  ID instruction reads rs / rt.
REQ-005 id_branch, id_branch_reg, id_halt  input  1 each  decoded Branch, BranchReg, Halt for the ID instruction.
REQ-006 id_branch_taken  input  1  branch condition true in ID; meaningful only when id_branch=1.
REQ-007 ex_mem_read, ex_reg_write, ex_sets_flags  input  1 each  MemRead, RegWrite, flag-write of the instruction in EX.
REQ-008 ex_rd  input  4  destination register of the instruction in EX.
REQ-009 mem_mem_read  input  1  MemRead of the instruction in MEM.
REQ-010 mem_rd  input  4  destination register of the instruction in MEM.
REQ-011 pc_stall, ifid_stall  output  1 each  hold PC / IF-ID register.
REQ-012 idex_flush, ifid_flush  output  1 each  load a NOP bubble into ID-EX / IF-ID.
REQ-013 halted  output  1  pipeline fully drained after HLT; sticky.

Function
REQ-014 Register 0 SHALL never cause a hazard; any comparison with rd=0 is false.
REQ-015 load_use SHALL be ex_mem_read & (ex_rd!=0) & ((id_uses_rs & ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)).
REQ-016 br_dep SHALL be id_branch_reg & (id_rs!=0) & ((ex_reg_write & ex_rd==id_rs) | (mem_mem_read & mem_rd==id_rs)).
REQ-017 flag_dep SHALL be id_branch & ~id_branch_reg & ex_sets_flags.
REQ-018 stall = load_use | br_dep | flag_dep; in RUN, stall SHALL combinationally assert pc_stall, ifid_stall, idex_flush in the same cycle and deassert ifid_flush.
REQ-019 In RUN with no stall, id_branch & id_branch_taken SHALL assert ifid_flush for exactly that cycle; all other outputs 0.
REQ-020 Stall SHALL take priority over branch flush and halt entry; a stalled branch or HLT is re-evaluated each cycle until stall clears.
REQ-021 States: RUN, DRAIN, HALTED; encoded in a 2-bit state register.
REQ-022 RUN -> DRAIN on the edge where id_halt=1 and stall=0; drain counter loaded with 3.
REQ-023 In DRAIN: pc_stall=1, ifid_flush=1, ifid_stall=0, idex_flush=0; counter decrements each cycle; at counter==0 next state HALTED.
REQ-024 Latency: halted SHALL rise exactly 4 cycles after the edge at which HLT left RUN (3 DRAIN cycles + transition).
REQ-025 In HALTED: pc_stall=1, ifid_stall=1, ifid_flush=1, idex_flush=1, halted=1; stays until rst.
REQ-026 Hazard inputs SHALL be ignored in DRAIN and HALTED.
REQ-027 Outputs other than halted SHALL be combinational from state and inputs; halted SHALL be registered.

Reset
REQ-028 On rst=1 at a clock edge: state=RUN, counter=0, halted=0; takes effect mid-DRAIN or in HALTED.
REQ-029 While rst=1 all outputs SHALL be 0 regardless of other inputs.

Configuration
REQ-030 Macro HAZARD_STALL_COUNT_EN SHALL, when defined, add output stall_cnt (16 bits) counting cycles with stall=1 in RUN, saturating at 16'hFFFF, cleared by rst.
REQ-031 Without HAZARD_STALL_COUNT_EN the port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-032 LW to R3 in EX, ID ADD uses rs=3 -> one cycle pc_stall=ifid_stall=idex_flush=1; next cycle (ex_mem_read=0) all 0.
REQ-033 LW to R0 in EX, ID uses rs=0 -> no stall; all outputs 0.
REQ-034 BR rs=5 in ID, ex_reg_write=1 ex_rd=5 -> stall; then mem_mem_read=1 mem_rd=5 -> stall; then clear with taken=1 -> ifid_flush=1 one cycle.
REQ-035 Taken B with ex_sets_flags=1 -> stall, ifid_flush=0; flags clear -> ifid_flush=1.
REQ-036 HLT in ID at cycle N, no stall -> DRAIN cycles N+1..N+3 (pc_stall=1, ifid_flush=1), halted=1 from cycle N+4 and held 20 cycles.
REQ-037 rst asserted in DRAIN cycle 2 -> next cycle state RUN, halted=0, stall_cnt=0 (with HAZARD_STALL_COUNT_EN); 5 back-to-back load-use cycles -> stall_cnt=5.

Source files
------------

// File: rtl/hazard_unit_if.sv
// Hazard unit interface: ID/EX/MEM hazard sources in, pipeline control out.
// master = pipeline side driving decode info; slave = hazard unit.
interface hazard_unit_if;
    logic [3:0] id_rs;
    logic [3:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       id_branch;
    logic       id_branch_reg;
    logic       id_halt;
    logic       id_branch_taken;
    logic       ex_mem_read;
    logic       ex_reg_write;
    logic       ex_sets_flags;
    logic [3:0] ex_rd;
    logic       mem_mem_read;
    logic [3:0] mem_rd;
    logic       pc_stall;
    logic       ifid_stall;
    logic       idex_flush;
    logic       ifid_flush;
    logic       halted;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_branch, id_branch_reg, id_halt,
               id_branch_taken, ex_mem_read, ex_reg_write, ex_sets_flags, ex_rd,
               mem_mem_read, mem_rd,
        input  pc_stall, ifid_stall, idex_flush, ifid_flush, halted
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_branch, id_branch_reg, id_halt,
               id_branch_taken, ex_mem_read, ex_reg_write, ex_sets_flags, ex_rd,
               mem_mem_read, mem_rd,
        output pc_stall, ifid_stall, idex_flush, ifid_flush, halted
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use / branch-register / flag stalls, taken-branch
// flush, and HLT drain sequence ending in a sticky halted state.
// Optional macro HAZARD_STALL_COUNT_EN adds a saturating 16-bit stall_cnt output.
module hazard_unit (
    input  logic         clk,
    input  logic         rst,
    hazard_unit_if.slave hz
`ifdef HAZARD_STALL_COUNT_EN
    ,
    output logic [15:0]  stall_cnt
`endif
);

    typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

    state_e     state_q, state_d;
    logic [1:0] drain_cnt_q, drain_cnt_d;
    logic       halted_q, halted_d;
    logic       load_use, br_dep, flag_dep, stall;

    // Hazard detection; register 0 never matches anything.
    always_comb begin
        load_use = hz.ex_mem_read && (hz.ex_rd != 4'd0) &&
                   ((hz.id_uses_rs && (hz.ex_rd == hz.id_rs)) ||
                    (hz.id_uses_rt && (hz.ex_rd == hz.id_rt)));
        br_dep   = hz.id_branch_reg && (hz.id_rs != 4'd0) &&
                   ((hz.ex_reg_write && (hz.ex_rd == hz.id_rs)) ||
                    (hz.mem_mem_read && (hz.mem_rd == hz.id_rs)));
        flag_dep = hz.id_branch && !hz.id_branch_reg && hz.ex_sets_flags;
        stall    = load_use || br_dep || flag_dep;
    end

    // Next-state: HLT enters DRAIN only when not stalled; drain ends after 3 cycles.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        halted_d    = halted_q;
        if (rst) begin
            state_d     = StRun;
            drain_cnt_d = 2'd0;
            halted_d    = 1'b0;
        end else begin
            case (state_q)
                StRun: begin
                    if (hz.id_halt && !stall) begin
                        state_d     = StDrain;
                        drain_cnt_d = 2'd3;
                    end
                end
                StDrain: begin
                    drain_cnt_d = drain_cnt_q - 2'd1;
                    // Counter reaching zero on this edge means the third drain cycle.
                    if (drain_cnt_q == 2'd1) begin
                        state_d  = StHalted;
                        halted_d = 1'b1;
                    end
                end
                StHalted: ;
                default: state_d = StRun;
            endcase
        end
    end

    // State register update.
    always_ff @(posedge clk) begin
        state_q     <= state_d;
        drain_cnt_q <= drain_cnt_d;
        halted_q    <= halted_d;
    end

    // Combinational pipeline controls; everything forced low while rst is high.
    always_comb begin
        hz.pc_stall   = 1'b0;
        hz.ifid_stall = 1'b0;
        hz.idex_flush = 1'b0;
        hz.ifid_flush = 1'b0;
        if (!rst) begin
            case (state_q)
                StRun: begin
                    if (stall) begin
                        hz.pc_stall   = 1'b1;
                        hz.ifid_stall = 1'b1;
                        hz.idex_flush = 1'b1;
                    end else if (hz.id_branch && hz.id_branch_taken) begin
                        hz.ifid_flush = 1'b1;
                    end
                end
                StDrain: begin
                    hz.pc_stall   = 1'b1;
                    hz.ifid_flush = 1'b1;
                end
                StHalted: begin
                    hz.pc_stall   = 1'b1;
                    hz.ifid_stall = 1'b1;
                    hz.idex_flush = 1'b1;
                    hz.ifid_flush = 1'b1;
                end
                default: ;
            endcase
        end
        hz.halted = halted_q && !rst;
    end

`ifdef HAZARD_STALL_COUNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of stalled RUN cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (rst) begin
            stall_cnt_d = 16'd0;
        end else if ((state_q == StRun) && stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = rst ? 16'd0 : stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized
// stimulus against a cycle-level behavioural model.
module tb_hazard_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    hazard_unit_if hif ();
`ifdef HAZARD_STALL_COUNT_EN
    logic [15:0] stall_cnt;
`endif

    hazard_unit dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif.slave)
`ifdef HAZARD_STALL_COUNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: mode 0 = running, 1 = draining, 2 = halted.
    int m_mode = 0;
    int m_left = 0;
    int m_cnt  = 0;

    logic [4:0] obs;
    assign obs = {hif.pc_stall, hif.ifid_stall, hif.idex_flush, hif.ifid_flush, hif.halted};

    function automatic bit m_stall();
        int rs = int'(hif.id_rs);
        int rt = int'(hif.id_rt);
        int exd = int'(hif.ex_rd);
        int md = int'(hif.mem_rd);
        bit lu, br, fl;
        lu = hif.ex_mem_read && exd != 0 &&
             ((hif.id_uses_rs && exd == rs) || (hif.id_uses_rt && exd == rt));
        br = hif.id_branch_reg && rs != 0 &&
             ((hif.ex_reg_write && exd == rs) || (hif.mem_mem_read && md == rs));
        fl = hif.id_branch && !hif.id_branch_reg && hif.ex_sets_flags;
        return lu || br || fl;
    endfunction

    function automatic logic [4:0] m_expect();
        if (rst) return 5'b00000;
        if (m_mode == 2) return 5'b11111;
        if (m_mode == 1) return 5'b10010;
        if (m_stall()) return 5'b11100;
        if (hif.id_branch && hif.id_branch_taken) return 5'b00010;
        return 5'b00000;
    endfunction

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic cycle();
        int nm = m_mode;
        int nl = m_left;
        int nc = m_cnt;
        bit st = m_stall();
        if (rst) begin
            nm = 0; nl = 0; nc = 0;
        end else if (m_mode == 0) begin
            if (st && nc < 65535) nc++;
            if (hif.id_halt && !st) begin nm = 1; nl = 3; end
        end else if (m_mode == 1) begin
            nl--;
            if (nl == 0) nm = 2;
        end
        @(posedge clk);
        m_mode = nm; m_left = nl; m_cnt = nc;
        #1;
    endtask

    task automatic set_idle();
        hif.id_rs = 4'd0; hif.id_rt = 4'd0;
        hif.id_uses_rs = 1'b0; hif.id_uses_rt = 1'b0;
        hif.id_branch = 1'b0; hif.id_branch_reg = 1'b0;
        hif.id_halt = 1'b0; hif.id_branch_taken = 1'b0;
        hif.ex_mem_read = 1'b0; hif.ex_reg_write = 1'b0; hif.ex_sets_flags = 1'b0;
        hif.ex_rd = 4'd0; hif.mem_mem_read = 1'b0; hif.mem_rd = 4'd0;
    endtask

    // Small register range so dependencies collide often.
    task automatic rand_inputs();
        hif.id_rs = 4'($urandom_range(0, 3)); hif.id_rt = 4'($urandom_range(0, 3));
        hif.id_uses_rs = 1'($urandom_range(0, 1)); hif.id_uses_rt = 1'($urandom_range(0, 1));
        hif.id_branch = 1'($urandom_range(0, 1)); hif.id_branch_reg = 1'($urandom_range(0, 1));
        hif.id_branch_taken = 1'($urandom_range(0, 1));
        hif.id_halt = ($urandom_range(0, 19) == 0);
        hif.ex_mem_read = 1'($urandom_range(0, 1)); hif.ex_reg_write = 1'($urandom_range(0, 1));
        hif.ex_sets_flags = ($urandom_range(0, 3) == 0);
        hif.ex_rd = 4'($urandom_range(0, 3));
        hif.mem_mem_read = 1'($urandom_range(0, 1)); hif.mem_rd = 4'($urandom_range(0, 3));
    endtask

    task automatic test_reset();
        rand_inputs();
        hif.ex_mem_read = 1'b1; hif.ex_rd = 4'd2; hif.id_uses_rs = 1'b1; hif.id_rs = 4'd2;
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== 5'b00000) begin
            failures++; $display("FAIL reset_outputs got=%b want=00000", obs);
        end
        cycle();
        rst = 1'b0;
        set_idle();
        #1;
        checks++;
        if (obs !== 5'b00000) begin
            failures++; $display("FAIL reset_release got=%b want=00000", obs);
        end
`ifdef HAZARD_STALL_COUNT_EN
        checks++;
        if (stall_cnt !== 16'd0) begin
            failures++; $display("FAIL reset_stall_cnt got=%0d want=0", stall_cnt);
        end
`endif
    endtask

    task automatic test_load_use();
        set_idle();
        hif.ex_mem_read = 1'b1; hif.ex_rd = 4'd3; hif.id_uses_rs = 1'b1; hif.id_rs = 4'd3;
        #1;
        checks++;
        if (obs !== 5'b11100) begin
            failures++; $display("FAIL load_use_rs got=%b want=11100", obs);
        end
        cycle();
        hif.ex_mem_read = 1'b0;
        #1;
        checks++;
        if (obs !== 5'b00000) begin
            failures++; $display("FAIL load_use_clear got=%b want=00000", obs);
        end
        cycle();
        hif.ex_mem_read = 1'b1; hif.ex_rd = 4'd0; hif.id_rs = 4'd0;
        #1;
        checks++;
        if (obs !== 5'b00000) begin
            failures++; $display("FAIL load_use_r0 got=%b want=00000", obs);
        end
        cycle();
        hif.id_uses_rs = 1'b0; hif.id_uses_rt = 1'b1; hif.id_rt = 4'd7; hif.ex_rd = 4'd7;
        #1;
        checks++;
        if (obs !== 5'b11100) begin
            failures++; $display("FAIL load_use_rt got=%b want=11100", obs);
        end
        cycle();
        set_idle();
    endtask

    task automatic test_branch_reg();
        set_idle();
        hif.id_branch = 1'b1; hif.id_branch_reg = 1'b1; hif.id_rs = 4'd5;
        hif.id_branch_taken = 1'b1;
        hif.ex_reg_write = 1'b1; hif.ex_rd = 4'd5;
        #1;
        checks++;
        if (obs !== 5'b11100) begin
            failures++; $display("FAIL br_dep_ex got=%b want=11100", obs);
        end
        cycle();
        hif.ex_reg_write = 1'b0; hif.ex_rd = 4'd0;
        hif.mem_mem_read = 1'b1; hif.mem_rd = 4'd5;
        #1;
        checks++;
        if (obs !== 5'b11100) begin
            failures++; $display("FAIL br_dep_mem got=%b want=11100", obs);
        end
        cycle();
        hif.mem_mem_read = 1'b0; hif.mem_rd = 4'd0;
        #1;
        checks++;
        if (obs !== 5'b00010) begin
            failures++; $display("FAIL br_taken_flush got=%b want=00010", obs);
        end
        cycle();
        set_idle();
        hif.id_branch = 1'b1; hif.id_branch_reg = 1'b1;
        hif.ex_reg_write = 1'b1;
        #1;
        checks++;
        if (obs !== 5'b00000) begin
            failures++; $display("FAIL br_dep_r0 got=%b want=00000", obs);
        end
        cycle();
        set_idle();
    endtask

    task automatic test_flag();
        set_idle();
        hif.id_branch = 1'b1; hif.id_branch_taken = 1'b1; hif.ex_sets_flags = 1'b1;
        #1;
        checks++;
        if (obs !== 5'b11100) begin
            failures++; $display("FAIL flag_dep got=%b want=11100", obs);
        end
        cycle();
        hif.ex_sets_flags = 1'b0;
        #1;
        checks++;
        if (obs !== 5'b00010) begin
            failures++; $display("FAIL flag_clear_flush got=%b want=00010", obs);
        end
        cycle();
        set_idle();
    endtask

    task automatic test_halt();
        set_idle();
        // HLT behind a load-use stall must wait.
        hif.id_halt = 1'b1;
        hif.ex_mem_read = 1'b1; hif.ex_rd = 4'd4; hif.id_uses_rt = 1'b1; hif.id_rt = 4'd4;
        #1;
        checks++;
        if (obs !== 5'b11100) begin
            failures++; $display("FAIL halt_stalled got=%b want=11100", obs);
        end
        cycle();
        hif.ex_mem_read = 1'b0;
        #1;
        checks++;
        if (obs !== 5'b00000) begin
            failures++; $display("FAIL halt_cycle_n got=%b want=00000", obs);
        end
        cycle();
        for (int i = 1; i <= 3; i++) begin
            rand_inputs();
            #1;
            checks++;
            if (obs !== 5'b10010) begin
                failures++; $display("FAIL halt_drain_%0d got=%b want=10010", i, obs);
            end
            cycle();
        end
        for (int i = 0; i < 20; i++) begin
            rand_inputs();
            #1;
            checks++;
            if (obs !== 5'b11111) begin
                failures++; $display("FAIL halt_held_%0d got=%b want=11111", i, obs);
            end
            cycle();
        end
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== 5'b00000) begin
            failures++; $display("FAIL halt_reset got=%b want=00000", obs);
        end
        cycle();
        rst = 1'b0;
        set_idle();
    endtask

    task automatic test_reset_mid_drain();
        set_idle();
        hif.id_halt = 1'b1;
        cycle();
        hif.id_halt = 1'b0;
        cycle();
        // Now in the second drain cycle.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== 5'b00000) begin
            failures++; $display("FAIL drain_reset_run got=%b want=00000", obs);
        end
`ifdef HAZARD_STALL_COUNT_EN
        checks++;
        if (stall_cnt !== 16'd0) begin
            failures++; $display("FAIL drain_reset_cnt got=%0d want=0", stall_cnt);
        end
`endif
        hif.ex_mem_read = 1'b1; hif.ex_rd = 4'd3; hif.id_uses_rs = 1'b1; hif.id_rs = 4'd3;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (obs !== 5'b11100) begin
                failures++; $display("FAIL b2b_stall_%0d got=%b want=11100", i, obs);
            end
            cycle();
        end
        set_idle();
        #1;
`ifdef HAZARD_STALL_COUNT_EN
        checks++;
        if (stall_cnt !== 16'd5) begin
            failures++; $display("FAIL b2b_stall_cnt got=%0d want=5", stall_cnt);
        end
`endif
        checks++;
        if (obs !== 5'b00000) begin
            failures++; $display("FAIL b2b_after got=%b want=00000", obs);
        end
    endtask

    task automatic test_random();
        logic [4:0] want;
        for (int i = 0; i < 600; i++) begin
            rand_inputs();
            rst = ($urandom_range(0, 29) == 0);
            #1;
            want = m_expect();
            checks++;
            if (obs !== want) begin
                failures++; $display("FAIL random_%0d got=%b want=%b", i, obs, want);
            end
`ifdef HAZARD_STALL_COUNT_EN
            checks++;
            if (stall_cnt !== (rst ? 16'd0 : 16'(m_cnt))) begin
                failures++; $display("FAIL random_cnt_%0d got=%0d want=%0d", i, stall_cnt,
                                     rst ? 0 : m_cnt);
            end
`endif
            cycle();
        end
        rst = 1'b0;
        set_idle();
    endtask

    initial begin
        set_idle();
        test_reset();
        test_load_use();
        test_branch_reg();
        test_flag();
        test_halt();
        test_reset_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
